// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Data-hazard unit beside the decode stage. Holds the decoded instruction
//   (ID register), tracks the destinations of the last FWD_DEPTH issued
//   instructions in a valid-tagged shift chain, and produces per-operand
//   forwarding selects plus a load-use stall.
//
//   Ports
//     clk, reset       clock; synchronous active-low reset
//     id_*             decoded instruction fields (valid, rs, rt, use_rs,
//                      use_rt, rd, we, is_load)
//     flush            kill the instruction currently held in the ID register
//     fwd_sel_a/b      0 = register file, k = result of chain stage k-1
//     stall            hold fetch/decode this cycle (combinational)
//     rd_last/we_last  destination / write qualifier of the oldest stage
//
//   Parameter constraints: 1 <= FWD_DEPTH <= 7, 2**SEL_W > FWD_DEPTH,
//   1 <= LD_LAT <= FWD_DEPTH-1.

// Per-stage comparator: one instance per chain entry.
module hazard_fwd_match #(
  parameter int REG_AW      = 5,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              valid,
  input  logic              we,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hit_rs,
  output logic              hit_rt
);
  logic live;

  // A hit implies rd equals the source, so excluding rd==0 excludes r0 reads.
  assign live   = valid & we & ~((ZERO_REG_EN != 0) && (rd == '0));
  assign hit_rs = live & (rd == rs);
  assign hit_rt = live & (rd == rt);
endmodule

module hazard_fwd_unit #(
  parameter int REG_AW      = 5,
  parameter int FWD_DEPTH   = 3,
  parameter int SEL_W       = 2,
  parameter int LD_LAT      = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic [REG_AW-1:0] rd_last,
  output logic              we_last
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } id_t;

  // Stages closer than LD_LAT cannot supply load data yet.
  localparam logic [FWD_DEPTH-1:0] LD_MASK = FWD_DEPTH'((1 << LD_LAT) - 1);

  id_t id_q, id_in;

  logic [FWD_DEPTH-1:0]             vld_pipe, we_pipe, ld_pipe;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] rd_pipe;
  logic [FWD_DEPTH-1:0]             hit_rs, hit_rt, use_hit_rs, use_hit_rt;
  logic                             advance;

  assign id_in = '{valid: id_valid, rs: id_rs, rt: id_rt, use_rs: id_use_rs,
                   use_rt: id_use_rt, rd: id_rd, we: id_we, ld: id_is_load};

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_stage
    hazard_fwd_match #(
      .REG_AW      (REG_AW),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match (
      .valid  (vld_pipe[k]),
      .we     (we_pipe[k]),
      .rd     (rd_pipe[k]),
      .rs     (id_q.rs),
      .rt     (id_q.rt),
      .hit_rs (hit_rs[k]),
      .hit_rt (hit_rt[k])
    );
  end

  assign use_hit_rs = hit_rs & {FWD_DEPTH{id_q.valid & id_q.use_rs}};
  assign use_hit_rt = hit_rt & {FWD_DEPTH{id_q.valid & id_q.use_rt}};

  // Stall length falls out naturally: bubbles push the load past LD_LAT.
  assign stall   = id_q.valid & ~flush &
                   (|(ld_pipe & LD_MASK & (use_hit_rs | use_hit_rt)));
  assign advance = ~stall & ~flush;

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (use_hit_rs[k]) fwd_sel_a = SEL_W'(k + 1);
      if (use_hit_rt[k]) fwd_sel_b = SEL_W'(k + 1);
    end
    if (stall) begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_q     <= '0;
      vld_pipe <= '0;
      we_pipe  <= '0;
      ld_pipe  <= '0;
      rd_pipe  <= '0;
    end else begin
      if (flush)       id_q <= '0;
      else if (!stall) id_q <= id_in;

      // Chain never stalls; a held or flushed ID slot issues a bubble.
      for (int k = 1; k < FWD_DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        we_pipe[k]  <= we_pipe[k-1];
        ld_pipe[k]  <= ld_pipe[k-1];
        rd_pipe[k]  <= rd_pipe[k-1];
      end
      if (advance) begin
        vld_pipe[0] <= id_q.valid;
        we_pipe[0]  <= id_q.we;
        ld_pipe[0]  <= id_q.ld;
        rd_pipe[0]  <= id_q.rd;
      end else begin
        vld_pipe[0] <= 1'b0;
        we_pipe[0]  <= 1'b0;
        ld_pipe[0]  <= 1'b0;
        rd_pipe[0]  <= '0;
      end
    end
  end

  assign rd_last = rd_pipe[FWD_DEPTH-1];
  assign we_last = vld_pipe[FWD_DEPTH-1] & we_pipe[FWD_DEPTH-1];
endmodule
